uart_dec_formatter: RTL and testbench
=====================================

Name: uart_dec_formatter

Overview:
Upstream feeder for the 8N1 UART transmitter. It accepts an unsigned binary value (e.g. the super counter count) and converts it to decimal ASCII by shift-add-3 (double-dabble). It then streams the digits, optionally followed by CR LF, one byte at a time into the transmitter's data/start/busy interface. It is the only driver of the transmitter's `data` and `start` inputs.

Parameters:
- VALUE_WIDTH, 16, width of the binary input value; must be ≥ 1.
- DIGITS, 5, number of BCD digits. Must satisfy 10^DIGITS > 2^VALUE_WIDTH − 1; an elaboration-time check fails otherwise.
- APPEND_CRLF, 1, when 1, append 0x0D then 0x0A after the last digit; when 0, send digits only.

Ports:
- clk  input  1  system clock, single domain
- rst  input  1  synchronous, active-high reset
- value_in  input  VALUE_WIDTH  unsigned value to print
- value_valid  input  1  request strobe; sampled only while ready=1
- ready  output  1  high in IDLE only; a request is accepted when value_valid && ready
- busy  output  1  equals !ready
- tx_data  output  8  byte to the transmitter's data input
- tx_start  output  1  one-cycle start pulse to the transmitter
- tx_busy  input  1  transmitter busy flag

Behaviour:
- Reset values: ready=1, busy=0, tx_start=0, tx_data=8'h00, FSM=IDLE, BCD register=0, digit index=DIGITS−1.
- Reset is synchronous and overrides everything. Reset mid-conversion or mid-send aborts: the FSM returns to IDLE with no further tx_start. A byte already started completes in the transmitter, which has its own reset.
- IDLE: on value_valid=1, latch value_in, clear BCD, load bit counter=VALUE_WIDTH, go to CONVERT.
- A value_valid while ready=0 is ignored (dropped, not queued).
- CONVERT: one double-dabble step per cycle.
  - Each BCD nibble ≥ 5 gets +3, then shift {bcd, bin} left by 1.
  - Exactly VALUE_WIDTH cycles, then go to SKIP with digit index=DIGITS−1.
- SKIP: leading-zero suppression.
  - While index > 0 and the nibble at index is 0, decrement index (one cycle per nibble).
  - Otherwise go to LOAD. Value 0 therefore prints "0".
- LOAD: if tx_busy=0:
  - tx_data = 8'h30 + nibble[index]; tx_start=1 for exactly this cycle; go to WAIT_HI.
  - If tx_busy=1, stay in LOAD.
- WAIT_HI: hold tx_data; wait until tx_busy=1, then go to WAIT_LO. This covers the one-cycle registered latency of the transmitter's busy flag. tx_start must never be reasserted here.
- WAIT_LO: wait until tx_busy=0. Next byte selection:
  - digit index > 0: decrement index, go to LOAD.
  - index=0 and APPEND_CRLF=1: send 0x0D, then 0x0A, each through the same LOAD/WAIT_HI/WAIT_LO sequence.
  - Otherwise go to IDLE; ready rises the cycle after the last tx_busy falling edge is seen.
- Invariants:
  - tx_start is high at most one cycle per byte.
  - tx_start is never asserted while tx_busy=1 or while in WAIT_HI/WAIT_LO.
  - tx_data is stable from the start pulse until WAIT_LO exits.
- Latency: acceptance → first tx_start = 1 + VALUE_WIDTH + (leading zeros) + 1 cycles, with tx_busy=0.
- Arithmetic: BCD register is 4·DIGITS bits; the +3 correction is 4-bit per nibble, never carries across nibbles. Input is treated as unsigned; the maximum value 2^VALUE_WIDTH−1 must print exactly.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, CONVERT, SKIP, LOAD, WAIT_HI, WAIT_LO);
  - ASCII constants ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - a function computing the minimum DIGITS for a given VALUE_WIDTH, used by the parameter check.
- One natural sub-module: bin_to_bcd_seq, the iterative double-dabble with start/done, parameterised by VALUE_WIDTH and DIGITS.
- The top module holds the suppression and byte-streaming FSM.

Test Plan:
Each directed test runs against the real transmitter with CLOCK_HZ/BAUD=4 and a serial decoder on serial_out.
- value_in=0, valid pulse → bytes 0x30,0x0D,0x0A; ready returns high afterwards.
- value_in=65535 → "65535\r\n" (0x36,0x35,0x35,0x33,0x35,0x0D,0x0A); first tx_start exactly 18 cycles after acceptance.
- value_in=1200 → "1200\r\n"; internal and trailing zeros kept, a single leading zero skipped.
- value_valid pulsed with value_in=7 during the send of 42 → only "42\r\n" emitted, no trace of 7. Throughout, assertion checks tx_start never high while tx_busy=1 or on consecutive cycles.
- rst asserted one cycle during the third byte of 12345 → no further tx_start after reset. A new request for 9 afterwards yields "9\r\n".
- APPEND_CRLF=0, VALUE_WIDTH=8, DIGITS=3, value_in=255 → exactly 0x32,0x35,0x35, then IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the decimal-to-UART formatter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

  // Byte-streaming FSM states.
  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SKIP,
    LOAD,
    WAIT_HI,
    WAIT_LO
  } state_e;

  // Which kind of byte is currently in flight.
  typedef enum logic [1:0] {
    SEL_DIGIT,
    SEL_CR,
    SEL_LF
  } byte_sel_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Decimal digits needed for 2^w - 1: floor(w * log10(2)) + 1.
  // log10(2) is scaled by 1e9. 2^w is never a power of ten, so the
  // truncated product is exact for any practical width.
  function automatic int min_digits(input int value_width);
    longint scaled;
    scaled = longint'(value_width) * 64'sd301029996;
    return int'(scaled / 64'sd1000000000) + 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter using shift-add-3 (double dabble).
// Latency: VALUE_WIDTH cycles after start_i. done_o is high during the final step.
// Backpressure: none. Result holds in bcd_o until the next start_i.
// Ports: clk/rst (sync, active-high), start_i + bin_i load a value,
//        done_o marks the last step, bcd_o gives DIGITS packed nibbles (digit 0 in LSBs).
module bin_to_bcd_seq
  import uart_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int DIGITS      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [VALUE_WIDTH-1:0] bin_i,
  output logic                   done_o,
  output logic [4*DIGITS-1:0]    bcd_o
);

  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // +3 correction is applied to each nibble on its own, so no carry crosses nibbles.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A non-zero counter means a conversion is running.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CNT_W'(VALUE_WIDTH);
    end else if (cnt_q != '0) begin
      bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[VALUE_WIDTH-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_dec_formatter.sv
// Prints an unsigned value as decimal ASCII (plus optional CR LF) into a UART transmitter.
// Latency: accept to first tx_start = VALUE_WIDTH + leading zeros + 2 cycles.
// Backpressure: ready is low while busy, and requests arriving then are dropped. Each byte waits for tx_busy to rise and then fall.
// Ports: clk/rst (sync, active-high); value_in/value_valid/ready/busy form the request side;
//        tx_data/tx_start/tx_busy connect to the transmitter.
module uart_dec_formatter
  import uart_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int DIGITS      = 5,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   value_valid,
  output logic                   ready,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy
);

  if (VALUE_WIDTH < 1) begin : g_bad_width
    $error("uart_dec_formatter: VALUE_WIDTH must be at least 1");
  end
  if (DIGITS < min_digits(VALUE_WIDTH)) begin : g_bad_digits
    $error("uart_dec_formatter: DIGITS too small for VALUE_WIDTH");
  end

  localparam int              IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  byte_sel_e           sel_q, sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                conv_start, conv_done;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          nib_cur, nib_lower;

  bin_to_bcd_seq #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .DIGITS     (DIGITS)
  ) u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start_i(conv_start),
    .bin_i  (value_in),
    .done_o (conv_done),
    .bcd_o  (bcd)
  );

  // Nibble at the current index, and the one below it for the next byte.
  always_comb begin
    nib_cur   = '0;
    nib_lower = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_q) == i)     nib_cur   = bcd[4*i +: 4];
      if (int'(idx_q) == i + 1) nib_lower = bcd[4*i +: 4];
    end
  end

  // tx_data_q is loaded on the transition into LOAD, so it is already
  // stable when tx_start fires. It then holds until the next LOAD.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    conv_start = 1'b0;
    tx_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          conv_start = 1'b1;
          idx_d      = IDX_TOP;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          idx_d   = IDX_TOP;
          state_d = SKIP;
        end
      end
      SKIP: begin
        // Digit 0 is never skipped, so a value of 0 prints "0".
        if (idx_q != '0 && nib_cur == 4'd0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          tx_data_d = ASCII_ZERO + {4'd0, nib_cur};
          sel_d     = SEL_DIGIT;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // The transmitter raises busy one cycle after the start pulse.
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = LOAD;
          if (sel_q == SEL_DIGIT && idx_q != '0) begin
            idx_d     = idx_q - 1'b1;
            tx_data_d = ASCII_ZERO + {4'd0, nib_lower};
          end else if (sel_q == SEL_DIGIT && APPEND_CRLF) begin
            sel_d     = SEL_CR;
            tx_data_d = ASCII_CR;
          end else if (sel_q == SEL_CR) begin
            sel_d     = SEL_LF;
            tx_data_d = ASCII_LF;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_DIGIT;
      idx_q     <= IDX_TOP;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = ~ready;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_dec_formatter.sv
// Bench for uart_dec_formatter: a 16-bit/CRLF instance and an 8-bit/no-CRLF instance.
// Each instance drives a behavioural transmitter whose busy flag is registered, and has its own scoreboard.
// Expected byte strings are pushed at request time. Monitors pop and compare on every tx_start.
module tb_uart_dec_formatter;

  localparam int BYTE_CYC = 40;  // 10 bit times at 4 clocks per bit

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] value_in;
  logic        value_valid, ready, busy, tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;

  logic [7:0]  value8;
  logic        valid8, ready8, busy8, tx_start8;
  logic [7:0]  tx_data8;
  logic        tx_busy8 = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int starts  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp8_q[$];

  uart_dec_formatter #(.VALUE_WIDTH(16), .DIGITS(5), .APPEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .ready(ready), .busy(busy), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy));

  uart_dec_formatter #(.VALUE_WIDTH(8), .DIGITS(3), .APPEND_CRLF(1'b0)) dut8 (
    .clk(clk), .rst(rst), .value_in(value8), .value_valid(valid8),
    .ready(ready8), .busy(busy8), .tx_data(tx_data8), .tx_start(tx_start8), .tx_busy(tx_busy8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transmitter models. Busy rises the cycle after start and stays high for BYTE_CYC cycles.
  int         tx_cnt = 0, tx_cnt8 = 0;
  logic [7:0] tx_cap = 8'h00, tx_cap8 = 8'h00;
  always @(posedge clk) begin
    if (tx_start && !tx_busy) begin
      tx_busy <= 1'b1; tx_cnt <= BYTE_CYC; tx_cap <= tx_data;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end
    if (tx_start8 && !tx_busy8) begin
      tx_busy8 <= 1'b1; tx_cnt8 <= BYTE_CYC; tx_cap8 <= tx_data8;
    end else if (tx_cnt8 > 0) begin
      tx_cnt8 <= tx_cnt8 - 1;
      if (tx_cnt8 == 1) tx_busy8 <= 1'b0;
    end
  end

  // Monitors: compare each started byte, check the start-pulse invariants and check tx_data stability.
  logic prev_start = 1'b0, prev_start8 = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      starts++;
      check("start_while_busy", {31'd0, tx_busy}, 32'd0);
      check("start_back_to_back", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
      end else check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    if (tx_busy && busy) check("data_stable", {24'd0, tx_data}, {24'd0, tx_cap});
    prev_start = tx_start;

    if (tx_start8) begin
      check("start_while_busy8", {31'd0, tx_busy8}, 32'd0);
      check("start_back_to_back8", {31'd0, prev_start8}, 32'd0);
      if (exp8_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_byte8: got 0x%0h, expected no byte", tx_data8);
      end else check("byte8", {24'd0, tx_data8}, {24'd0, exp8_q.pop_front()});
    end
    if (tx_busy8 && busy8) check("data_stable8", {24'd0, tx_data8}, {24'd0, tx_cap8});
    prev_start8 = tx_start8;
  end

  task automatic push_str(input bit is8, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (is8) exp8_q.push_back(s[i]);
      else     exp_q.push_back(s[i]);
    end
  endtask

  // Issue a one-cycle request. Then count the cycles from acceptance to the first tx_start.
  task automatic request(input bit is8, input logic [15:0] v, input string name, input int exp_lat);
    int n;
    n = 0;
    while (!(is8 ? ready8 : ready) && n < 5000) begin @(posedge clk); #1; n++; end
    if (is8) begin value8 = v[7:0]; valid8 = 1'b1; end
    else begin value_in = v; value_valid = 1'b1; end
    @(posedge clk); #1;
    valid8 = 1'b0;
    value_valid = 1'b0;
    n = 1;
    while (!(is8 ? tx_start8 : tx_start) && n < 200) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic wait_done(input bit is8, input string name);
    int n;
    n = 0;
    while (n < 5000 && !(is8 ? (exp8_q.size() == 0 && ready8 && !tx_busy8)
                             : (exp_q.size() == 0 && ready && !tx_busy))) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_done_in_time"}, {31'd0, n < 5000}, 32'd1);
  endtask

  initial begin
    int s0, n;
    rst = 1'b1; value_in = '0; value_valid = 1'b0; value8 = '0; valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_ready8", {31'd0, ready8}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero prints a single "0". Four leading zeros are skipped.
    push_str(0, "0\r\n");
    request(0, 16'd0, "zero", 22);
    wait_done(0, "zero");

    // Maximum value, with no leading zeros.
    push_str(0, "65535\r\n");
    request(0, 16'hFFFF, "max", 18);
    wait_done(0, "max");

    // Internal and trailing zeros are kept. One leading zero is skipped.
    push_str(0, "1200\r\n");
    request(0, 16'd1200, "v1200", 19);
    wait_done(0, "v1200");

    // A request while busy is dropped.
    push_str(0, "42\r\n");
    request(0, 16'd42, "v42", 21);
    repeat (10) @(posedge clk);
    #1;
    check("busy_during_send", {31'd0, busy}, 32'd1);
    value_in = 16'd7; value_valid = 1'b1;
    @(posedge clk); #1;
    value_valid = 1'b0;
    wait_done(0, "v42");
    s0 = starts;
    repeat (100) @(posedge clk);
    #1;
    check("dropped_req_no_bytes", starts - s0, 0);
    check("dropped_req_ready", {31'd0, ready}, 32'd1);

    // Reset during the third byte of 12345 aborts the rest of the message.
    push_str(0, "123");
    request(0, 16'd12345, "v12345", 18);
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("third_byte_started", {31'd0, n < 2000}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_tx_start", {31'd0, tx_start}, 32'd0);
    check("abort_tx_data", {24'd0, tx_data}, 32'd0);
    s0 = starts;
    repeat (300) @(posedge clk);
    #1;
    check("abort_no_more_starts", starts - s0, 0);
    push_str(0, "9\r\n");
    request(0, 16'd9, "v9", 22);
    wait_done(0, "v9");

    // 8-bit instance without CR LF.
    push_str(1, "255");
    request(1, 16'd255, "v255_w8", 10);
    wait_done(1, "v255_w8");
    repeat (50) @(posedge clk);
    #1;
    check("w8_idle_after", {31'd0, ready8}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
